// File: rtl/fire_expand3_ofm_writer_pkg.sv
// Shared constants and types for the fire expand3 output-feature-map writer.
//
// Contents:
//   WIDTH, DSP_NO, WOUT  - default word width, channels per sample, OFM side length
//   addr_width()         - RAM word-address width for a given channel count / side length
//   pix_width()          - pixel counter width able to hold WOUT^2 (saturation value)
//   ADDR_W               - address width at the default sizes (18)
//   ofm_state_t          - writer FSM states
package fire_expand3_ofm_writer_pkg;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 64;
    localparam int WOUT   = 64;

    function automatic int addr_width(input int dsp_no, input int wout);
        return $clog2(dsp_no * wout * wout);
    endfunction

    // One extra code beyond the last pixel index so pix can park at WOUT^2.
    function automatic int pix_width(input int wout);
        return $clog2(wout * wout + 1);
    endfunction

    localparam int ADDR_W = addr_width(DSP_NO, WOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } ofm_state_t;

endpackage

// File: rtl/fire_expand3_ofm_writer.sv
// Fire expand3 OFM writer: captures one pixel of DSP_NO parallel channel results
// and serialises it into a channel-major feature-map RAM, one word per cycle.
//
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start          - one-cycle pulse: rearm for a new layer (aborts any drain)
//   sample         - strobe: ofm holds a valid pixel; only accepted in IDLE.
//                    There is no back-pressure: a strobe that arrives while the
//                    block is DRAIN or DONE is dropped and flagged on overflow.
//   ofm            - DSP_NO channel words for the current pixel
//   layer_finish   - expand layer's finish flag
//   wr_en/wr_addr/wr_data - registered RAM write port (addr = ch*WOUT^2 + pix)
//   ram_feedback   - single-cycle acknowledge once the whole layer is written
//   busy           - high while in DRAIN
//   overflow       - sticky dropped-sample flag, cleared by start/rst
//   state_dbg      - current FSM state (ofm_state_t encoding)
//   pix_dbg        - current pixel counter
module fire_expand3_ofm_writer #(
    parameter int WIDTH  = fire_expand3_ofm_writer_pkg::WIDTH,
    parameter int DSP_NO = fire_expand3_ofm_writer_pkg::DSP_NO,
    parameter int WOUT   = fire_expand3_ofm_writer_pkg::WOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample,
    input  logic [WIDTH-1:0] ofm [DSP_NO],
    input  logic             layer_finish,
    output logic             wr_en,
    output logic [fire_expand3_ofm_writer_pkg::addr_width(DSP_NO, WOUT)-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             ram_feedback,
    output logic             busy,
    output logic             overflow,
    output logic [1:0]       state_dbg,
    output logic [fire_expand3_ofm_writer_pkg::pix_width(WOUT)-1:0] pix_dbg
);
    import fire_expand3_ofm_writer_pkg::*;

    localparam int PIX_N = WOUT * WOUT;
    localparam int A_W   = addr_width(DSP_NO, WOUT);
    localparam int P_W   = pix_width(WOUT);
    localparam int C_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

    ofm_state_t       state;
    logic [WIDTH-1:0] ofm_buf [DSP_NO];
    logic [C_W-1:0]   ch;
    logic [C_W-1:0]   ch_nxt;
    logic [P_W-1:0]   pix;
    logic             fb_issued;
    logic             capture;

    function automatic logic [A_W-1:0] word_addr(input logic [C_W-1:0] c, input logic [P_W-1:0] p);
        return A_W'(c) * A_W'(PIX_N) + A_W'(p);
    endfunction

    always_comb begin
        capture = 1'b0;
        ch_nxt  = ch + 1'b1;
        if (!rst && !start && sample && state == ST_IDLE) begin
            capture = 1'b1;
        end
    end

    // Pixel buffer holds data only; it is never cleared.
    always_ff @(posedge clk) begin
        if (capture) begin
            ofm_buf <= ofm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            state        <= ST_IDLE;
            ch           <= '0;
            pix          <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            ram_feedback <= 1'b0;
            overflow     <= 1'b0;
            fb_issued    <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            ram_feedback <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sample) begin
                        // Channel 0 is written straight from the input on the
                        // capture edge, so wr_en lines up exactly with DRAIN.
                        state   <= ST_DRAIN;
                        ch      <= '0;
                        wr_en   <= 1'b1;
                        wr_data <= ofm[0];
                        wr_addr <= word_addr('0, pix);
                    end
                end
                ST_DRAIN: begin
                    if (sample) begin
                        overflow <= 1'b1;
                    end
                    if (ch == C_W'(DSP_NO - 1)) begin
                        // pix < PIX_N here, so the increment cannot wrap; it
                        // parks at PIX_N once the last pixel is written.
                        pix   <= pix + 1'b1;
                        state <= (pix == P_W'(PIX_N - 1)) ? ST_DONE : ST_IDLE;
                    end else begin
                        ch      <= ch_nxt;
                        wr_en   <= 1'b1;
                        wr_data <= ofm_buf[ch_nxt];
                        wr_addr <= word_addr(ch_nxt, pix);
                    end
                end
                ST_DONE: begin
                    if (sample) begin
                        overflow <= 1'b1;
                    end
                    if (layer_finish && !fb_issued) begin
                        ram_feedback <= 1'b1;
                        fb_issued    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_DRAIN);
    assign state_dbg = state;
    assign pix_dbg   = pix;

endmodule

// File: tb/tb_fire_expand3_ofm_writer.sv
// Bench for fire_expand3_ofm_writer at a reduced size (8 channels, 4x4 map)
// so complete layers fit in a short run. Addresses scale as ch*16 + pix.
module tb_fire_expand3_ofm_writer;

  localparam int WIDTH  = 16;
  localparam int DSP_NO = 8;
  localparam int WOUT   = 4;
  localparam int PIX_N  = WOUT * WOUT;
  localparam int A_W    = 7;
  localparam int P_W    = 5;
  localparam int E_W    = A_W + WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             start;
  logic             sample;
  logic [WIDTH-1:0] ofm [DSP_NO];
  logic             layer_finish;
  logic             wr_en;
  logic [A_W-1:0]   wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             ram_feedback;
  logic             busy;
  logic             overflow;
  logic [1:0]       state_dbg;
  logic [P_W-1:0]   pix_dbg;

  fire_expand3_ofm_writer #(
    .WIDTH (WIDTH),
    .DSP_NO(DSP_NO),
    .WOUT  (WOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sample      (sample),
    .ofm         (ofm),
    .layer_finish(layer_finish),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ram_feedback(ram_feedback),
    .busy        (busy),
    .overflow    (overflow),
    .state_dbg   (state_dbg),
    .pix_dbg     (pix_dbg)
  );

  // scoreboard
  logic [E_W-1:0] exp_q[$];
  int             passed = 0;
  int             checks = 0;
  int             fails  = 0;
  int             fb_count = 0;
  int             m_pix = 0;
  logic [A_W-1:0] last_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [E_W-1:0] exp_w;
    if (ram_feedback) fb_count++;
    if (wr_en) begin
      check("write_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", {wr_addr, wr_data}, exp_w);
      end
      last_addr = wr_addr;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    m_pix = 0;
  endtask

  // mode 0: ofm[i] = i+1; mode 1: random words with frequent zeros.
  // push=1 queues the DSP_NO writes this sample must produce.
  task automatic drive_sample(input int mode, input bit push);
    for (int i = 0; i < DSP_NO; i++) begin
      if (mode == 0) ofm[i] = WIDTH'(i + 1);
      else ofm[i] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
    end
    if (push) begin
      for (int c = 0; c < DSP_NO; c++) begin
        exp_q.push_back({A_W'(c * PIX_N + m_pix), ofm[c]});
      end
      m_pix++;
    end
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
  endtask

  task automatic run_layer();
    for (int p = 0; p < PIX_N - 1; p++) begin
      drive_sample(1, 1'b1);
      tick($urandom_range(DSP_NO, DSP_NO + 5));
    end
    drive_sample(1, 1'b1);
    tick(DSP_NO);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sample = 1'b0;
    layer_finish = 1'b0;
    for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    settle();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ram_feedback", ram_feedback, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_pix", pix_dbg, 0);
    rst = 1'b0;

    // single sample, data i+1, addresses ch*16
    pulse_start();
    drive_sample(0, 1'b1);
    settle();
    check("first_cycle_wr_en", wr_en, 1);
    check("first_cycle_busy", busy, 1);
    check("first_cycle_state", state_dbg, S_DRAIN);
    tick(DSP_NO);
    check("single_drain_all_written", exp_q.size(), 0);
    check("single_state_idle", state_dbg, S_IDLE);
    check("single_busy_low", busy, 0);
    check("single_wr_en_low", wr_en, 0);
    check("single_pix", pix_dbg, 1);
    check("single_no_overflow", overflow, 0);

    // second sample mid-drain: dropped, flagged, first drain intact
    drive_sample(1, 1'b1);
    tick(2);
    drive_sample(1, 1'b0);
    tick(DSP_NO);
    check("ovf_flag", overflow, 1);
    check("ovf_drain_complete", exp_q.size(), 0);
    check("ovf_pix", pix_dbg, 2);
    check("ovf_state_idle", state_dbg, S_IDLE);

    // start and sample on the same edge: start wins, overflow cleared
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'($urandom);
    start = 1'b1;
    sample = 1'b1;
    tick(1);
    start = 1'b0;
    sample = 1'b0;
    m_pix = 0;
    settle();
    check("start_sample_state", state_dbg, S_IDLE);
    check("start_sample_overflow", overflow, 0);
    check("start_sample_wr_en", wr_en, 0);
    check("start_sample_pix", pix_dbg, 0);
    tick(DSP_NO + 2);
    check("start_sample_no_writes", exp_q.size(), 0);

    // reset in the middle of a drain
    drive_sample(1, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("middrain_writes_so_far", exp_q.size(), DSP_NO - 4);
    rst = 1'b1;
    settle();
    check("middrain_rst_wr_en", wr_en, 0);
    check("middrain_rst_wr_addr", wr_addr, 0);
    check("middrain_rst_wr_data", wr_data, 0);
    check("middrain_rst_busy", busy, 0);
    check("middrain_rst_pix", pix_dbg, 0);
    check("middrain_rst_state", state_dbg, S_IDLE);
    rst = 1'b0;
    exp_q.delete();
    m_pix = 0;
    tick(DSP_NO);
    check("middrain_no_more_writes", busy, 0);

    // full layer with layer_finish low, then raised
    pulse_start();
    run_layer();
    settle();
    check("layer_state_done", state_dbg, S_DONE);
    check("layer_all_written", exp_q.size(), 0);
    check("layer_last_addr", last_addr, DSP_NO * PIX_N - 1);
    check("layer_pix_saturated", pix_dbg, PIX_N);
    check("layer_busy_low", busy, 0);
    fb_count = 0;
    tick(10);
    check("no_feedback_without_finish", fb_count, 0);
    drive_sample(1, 1'b0);
    tick(3);
    check("done_sample_overflow", overflow, 1);
    check("done_pix_held", pix_dbg, PIX_N);
    check("done_state_held", state_dbg, S_DONE);
    layer_finish = 1'b1;
    tick(10);
    check("feedback_one_pulse", fb_count, 1);
    layer_finish = 1'b0;
    tick(5);
    layer_finish = 1'b1;
    tick(5);
    check("feedback_no_second_pulse", fb_count, 1);

    // layer_finish already high when DONE is entered
    pulse_start();
    fb_count = 0;
    check("restart_overflow_cleared", overflow, 0);
    run_layer();
    settle();
    check("early_finish_state_done", state_dbg, S_DONE);
    check("early_finish_no_pulse_yet", fb_count, 0);
    tick(1);
    settle();
    check("early_finish_pulse_next_edge", fb_count, 1);
    tick(10);
    check("early_finish_single_pulse", fb_count, 1);
    check("early_finish_all_written", exp_q.size(), 0);
    layer_finish = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
